// File: rtl/pm_resp_ctrl.sv
// pm_resp_ctrl - program-memory responder for the sequencer's PM fetch port.
//
// Holds a 2^ADDR_W x 32 instruction store. After reset the store is booted
// from a little-endian byte stream using a valid/ready handshake. Once
// BOOT_WORDS words have been loaded, the block serves sequencer reads
// (1-cycle latency) and writes.
//
// Optional build macro: PM_PARITY_EN. When it is defined, each stored word
// carries an even-parity bit and pm_par_err flags a parity error on the
// current pm_ps_op.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   ps_pm_cslt      sequencer chip select
//   ps_pm_wrb       1 = write, 0 = read (qualified by ps_pm_cslt)
//   ps_pm_add       word address; only [ADDR_W-1:0] is decoded
//   bc_pm_dt        write data for sequencer writes
//   pm_ps_op        registered opcode returned to the sequencer
//   ld_dt/ld_vld    boot byte and its valid strobe
//   ld_rdy          ready for a boot byte (BOOT only)
//   pm_boot_done    high once the RUN state is entered
//   pm_par_err      parity error flag aligned with pm_ps_op
module pm_resp_ctrl #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned BOOT_WORDS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps_pm_cslt,
  input  logic        ps_pm_wrb,
  input  logic [15:0] ps_pm_add,
  input  logic [31:0] bc_pm_dt,
  output logic [31:0] pm_ps_op,
  input  logic [7:0]  ld_dt,
  input  logic        ld_vld,
  output logic        ld_rdy,
  output logic        pm_boot_done,
  output logic        pm_par_err
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(BOOT_WORDS - 1);

  typedef enum logic {BOOT, RUN} state_t;

  state_t            state;
  logic [1:0]        byte_cnt;
  logic [ADDR_W-1:0] word_cnt;
  logic [23:0]       asm_reg;

  logic [31:0]       mem [DEPTH];

  logic [ADDR_W-1:0] addr;
  logic              accept;
  logic              boot_wr;
  logic [31:0]       boot_word;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  // Upper address bits are deliberately ignored (aliasing).
  logic              addr_hi_unused;
  assign addr_hi_unused = ^ps_pm_add[15:ADDR_W];

  assign addr = ps_pm_add[ADDR_W-1:0];

  // Combinational so it drops immediately with rst and the cycle after RUN.
  assign ld_rdy = (state == BOOT) && !rst;

`ifdef PM_PARITY_EN
  logic mem_par [DEPTH];
  logic par_err_q;
  assign pm_par_err = par_err_q;
`else
  assign pm_par_err = 1'b0;
`endif

  // Single write port shared by the boot loader and the sequencer; the two
  // sources are mutually exclusive by state.
  always_comb begin
    accept    = ld_rdy && ld_vld;
    boot_word = {ld_dt, asm_reg};
    boot_wr   = accept && (byte_cnt == 2'd3);
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    if (boot_wr) begin
      wr_en   = 1'b1;
      wr_addr = word_cnt;
      wr_data = boot_word;
    end else if (state == RUN && ps_pm_cslt && ps_pm_wrb) begin
      wr_en   = 1'b1;
      wr_addr = addr;
      wr_data = bc_pm_dt;
    end
  end

  // Storage is not reset; words written before a reset survive it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
`ifdef PM_PARITY_EN
      mem_par[wr_addr] <= ^wr_data;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= BOOT;
      byte_cnt     <= '0;
      word_cnt     <= '0;
      asm_reg      <= '0;
      pm_ps_op     <= '0;
      pm_boot_done <= 1'b0;
`ifdef PM_PARITY_EN
      par_err_q    <= 1'b0;
`endif
    end else begin
      case (state)
        BOOT: begin
          pm_ps_op <= '0;
`ifdef PM_PARITY_EN
          par_err_q <= 1'b0;
`endif
          if (accept) begin
            case (byte_cnt)
              2'd0:    asm_reg[7:0]   <= ld_dt;
              2'd1:    asm_reg[15:8]  <= ld_dt;
              2'd2:    asm_reg[23:16] <= ld_dt;
              default: ;
            endcase
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              word_cnt <= word_cnt + 1'b1;
              if (word_cnt == LAST_WORD) begin
                state        <= RUN;
                pm_boot_done <= 1'b1;
              end
            end
          end
        end
        RUN: begin
          pm_boot_done <= 1'b1;
          if (ps_pm_cslt && !ps_pm_wrb) begin
            pm_ps_op <= mem[addr];
`ifdef PM_PARITY_EN
            par_err_q <= ^{mem[addr], mem_par[addr]};
`endif
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_pm_resp_ctrl.sv
// tb_pm_resp_ctrl - randomized self-checking bench for pm_resp_ctrl.
// A reference model holds the expected store as an array, assembles boot
// words from a byte queue, and predicts pm_ps_op / flags every cycle.
module tb_pm_resp_ctrl;

  localparam int unsigned ADDR_W     = 8;
  localparam int unsigned BOOT_WORDS = 2;
  localparam int unsigned DEPTH      = 1 << ADDR_W;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cslt = 1'b0;
  logic        wrb = 1'b0;
  logic [15:0] add = '0;
  logic [31:0] bc_dt = '0;
  logic [31:0] op;
  logic [7:0]  ld_dt = '0;
  logic        ld_vld = 1'b0;
  logic        ld_rdy;
  logic        boot_done;
  logic        par_err;

  pm_resp_ctrl #(.ADDR_W(ADDR_W), .BOOT_WORDS(BOOT_WORDS)) dut (
    .clk          (clk),
    .rst          (rst),
    .ps_pm_cslt   (cslt),
    .ps_pm_wrb    (wrb),
    .ps_pm_add    (add),
    .bc_pm_dt     (bc_dt),
    .pm_ps_op     (op),
    .ld_dt        (ld_dt),
    .ld_vld       (ld_vld),
    .ld_rdy       (ld_rdy),
    .pm_boot_done (boot_done),
    .pm_par_err   (par_err)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model
  logic [31:0] m_mem [DEPTH];
  bit          m_written [DEPTH];
  bit          m_par_bad [DEPTH];
  logic [7:0]  q [$];
  int unsigned m_words;
  bit          m_done;
  logic [31:0] m_op;
  bit          m_perr;

  task automatic model_reset();
    q.delete();
    m_words = 0;
    m_done  = 0;
    m_op    = '0;
    m_perr  = 0;
  endtask

  // Apply the currently driven inputs at the next edge, then compare.
  task automatic tick();
    int unsigned a;
    @(posedge clk);
    if (!m_done) begin
      if (ld_vld) begin
        q.push_back(ld_dt);
        if (q.size() == 4) begin
          m_mem[m_words]     = {q[3], q[2], q[1], q[0]};
          m_written[m_words] = 1;
          m_par_bad[m_words] = 0;
          q.delete();
          m_words++;
          if (m_words == BOOT_WORDS) m_done = 1;
        end
      end
    end else if (cslt) begin
      a = 32'(add) % DEPTH;
      if (wrb) begin
        m_mem[a]     = bc_dt;
        m_written[a] = 1;
        m_par_bad[a] = 0;
      end else begin
        m_op   = m_mem[a];
        m_perr = m_par_bad[a];
      end
    end
    #1;
    check("op", op, m_op);
    check("ld_rdy", {31'b0, ld_rdy}, {31'b0, !m_done});
    check("boot_done", {31'b0, boot_done}, {31'b0, m_done});
    check("par_err", {31'b0, par_err}, {31'b0, m_perr});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_ld_rdy", {31'b0, ld_rdy}, 32'd0);
    check("rst_op", op, 32'd0);
    check("rst_done", {31'b0, boot_done}, 32'd0);
    check("rst_perr", {31'b0, par_err}, 32'd0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("ld_rdy_after_rst", {31'b0, ld_rdy}, 32'd1);
  endtask

  task automatic run_random();
    cslt   = ($urandom_range(0, 3) != 0);
    wrb    = ($urandom_range(0, 2) == 0);
    add    = 16'($urandom);
    bc_dt  = $urandom;
    ld_vld = 1'($urandom);
    ld_dt  = 8'($urandom);
    // Only read words the model knows; unknown addresses fall back to word 0.
    if (cslt && !wrb && !m_written[32'(add) % DEPTH]) add = add & 16'hFF00;
    tick();
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0]  plan [8];
    int unsigned acc;
    int unsigned cyc;
    int unsigned nret;

    plan = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    #2;
    do_reset();

    // Boot with random gaps, aborted by reset after 6 accepted bytes.
    acc = 0;
    cyc = 0;
    while (acc < 6 && cyc < 100) begin
      ld_vld = ($urandom_range(0, 2) != 0);
      ld_dt  = 8'($urandom);
      cslt   = 1'($urandom);
      wrb    = 1'($urandom);
      add    = 16'($urandom);
      bc_dt  = $urandom;
      if (ld_vld) acc++;
      tick();
      cyc++;
    end
    check("abort_bytes", acc, 32'd6);
    ld_vld = 1'b0;
    do_reset();

    // Full boot with random bytes and gaps, then random RUN traffic.
    cyc = 0;
    while (!m_done && cyc < 200) begin
      ld_vld = ($urandom_range(0, 2) != 0);
      ld_dt  = 8'($urandom);
      cslt   = 1'($urandom);
      wrb    = 1'($urandom);
      add    = 16'($urandom);
      bc_dt  = $urandom;
      tick();
      cyc++;
    end
    check("boot2_done", {31'b0, boot_done}, 32'd1);
    for (int i = 0; i < 200; i++) run_random();

    // Reference boot stream, continuous valid; sequencer writes ignored.
    ld_vld = 1'b0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      ld_vld = 1'b1;
      ld_dt  = plan[i];
      cslt   = 1'b1;
      wrb    = 1'b1;
      add    = 16'(i + 8);
      bc_dt  = $urandom;
      tick();
      if (i == 6) check("done_before_last", {31'b0, boot_done}, 32'd0);
    end
    ld_vld = 1'b0;
    check("done_after_last", {31'b0, boot_done}, 32'd1);
    check("ld_rdy_run", {31'b0, ld_rdy}, 32'd0);

    // Words written before the reset survive it.
    nret = 0;
    for (int a = 2; a < int'(DEPTH) && nret < 8; a++) begin
      if (m_written[a]) begin
        cslt = 1'b1;
        wrb  = 1'b0;
        add  = 16'(a);
        tick();
        nret++;
      end
    end

    cslt = 1'b1;
    wrb  = 1'b0;
    add  = 16'd0;
    tick();
    check("rd0", op, 32'h12345678);
    add = 16'd1;
    tick();
    check("rd1", op, 32'hDEADBEEF);

    cslt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ld_vld = 1'(i % 2);
      ld_dt  = 8'($urandom);
      add    = 16'($urandom);
      wrb    = 1'($urandom);
      tick();
      check("idle_hold", op, 32'hDEADBEEF);
    end
    ld_vld = 1'b0;

    cslt  = 1'b1;
    wrb   = 1'b1;
    add   = 16'd5;
    bc_dt = 32'hCAFEF00D;
    tick();
    check("wr_hold", op, 32'hDEADBEEF);
    wrb   = 1'b0;
    bc_dt = '0;
    tick();
    check("rd5", op, 32'hCAFEF00D);
    add = 16'h0105;
    tick();
    check("rd105_alias", op, 32'hCAFEF00D);
    add = 16'h0100;
    tick();
    check("rd100_alias", op, 32'h12345678);

`ifdef PM_PARITY_EN
    dut.mem_par[1] = ~dut.mem_par[1];
    m_par_bad[1] = 1;
    add = 16'd1;
    tick();
    check("perr_addr1", {31'b0, par_err}, 32'd1);
    check("perr_addr1_data", op, 32'hDEADBEEF);
    add = 16'd0;
    tick();
    check("perr_addr0", {31'b0, par_err}, 32'd0);
`endif

    for (int i = 0; i < 50; i++) run_random();
    cslt = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
